// File: rtl/sbox_share_sched.sv
// sbox_share_sched
//   Time-shares a single 32-bit combinational S-box (four byte lanes) between
//   the round datapath (SubBytes on a 128-bit state, four words) and the key
//   schedule (SubWord on one 32-bit word). Contested cycles are arbitrated
//   round-robin, so neither requester can starve the other.
//
// Ports
//   clk       in   1    system clock, rising edge
//   rst_n     in   1    synchronous active-low reset
//   st_valid  in   1    state job request
//   st_ready  out  1    high while idle; a job is accepted on st_valid & st_ready
//   st_in     in   128  state to substitute, word0 = [127:96] .. word3 = [31:0]
//   st_out    out  128  substituted state, valid while st_done is high
//   st_done   out  1    one-cycle completion pulse for the state job
//   kw_valid  in   1    key word request (may be held high for back-to-back words)
//   kw_ready  out  1    key word granted the S-box this cycle
//   kw_in     in   32   word for SubWord
//   kw_out    out  32   substituted key word, valid while kw_done is high
//   kw_done   out  1    one-cycle completion pulse for a key word
//   sbox_in   out  32   drives the shared S-box input
//   sbox_out  in   32   result from the shared S-box
//
// Parameter
//   KEY_FIRST  winner of the first contested cycle after reset (1 = key, 0 = state)
//
// Build option
//   SBOX_PIPE_EN  when defined, sbox_out is captured in a register together with
//                 an {owner, index} tag and results retire one cycle after their
//                 grant; done pulses and the return to idle move one cycle later.
module sbox_share_sched #(
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_in,
  output logic [31:0]  kw_out,
  output logic         kw_done,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  // Issue index of the next state word; bit 2 set means all four words issued.
  logic [2:0]   idx_q, idx_d;
  logic [127:0] job_q, job_d;
  logic [127:0] res_q, res_d;
  logic [127:0] st_out_q, st_out_d;
  logic         st_done_q, st_done_d;
  logic [31:0]  kw_out_q, kw_out_d;
  logic         kw_done_q, kw_done_d;
  // Owner of the most recent contested grant: 1 = key, 0 = state.
  logic         last_key_q, last_key_d;

  logic         st_cand_s;
  logic         contest_s;
  logic         key_win_s;
  logic         st_win_s;
  logic         ret_vld_s;
  logic         ret_key_s;
  logic [1:0]   ret_idx_s;
  logic [31:0]  ret_data_s;

`ifdef SBOX_PIPE_EN
  logic         pipe_vld_q, pipe_vld_d;
  logic         pipe_key_q, pipe_key_d;
  logic [1:0]   pipe_idx_q, pipe_idx_d;
  logic [31:0]  pipe_data_q, pipe_data_d;
`endif

  // Select word n of a 128-bit block, word0 being the most significant.
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] n);
    logic [31:0] w;
    case (n)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  // Replace word n of a 128-bit block, word0 being the most significant.
  function automatic logic [127:0] word_put(input logic [127:0] blk, input logic [1:0] n,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = blk;
    case (n)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // Arbitration and S-box input mux; purely combinational.
  always_comb begin
    // The state job only competes once it is running, so a key word can take
    // the S-box in the very cycle a state job is being accepted.
    st_cand_s = (fsm_q == RUN) && !idx_q[2];
    contest_s = st_cand_s && kw_valid;
    if (contest_s) begin
      key_win_s = ~last_key_q;
    end else begin
      key_win_s = kw_valid;
    end
    st_win_s = st_cand_s && !key_win_s;

    if (st_win_s) begin
      sbox_in = word_sel(job_q, idx_q[1:0]);
    end else if (key_win_s) begin
      sbox_in = kw_in;
    end else begin
      sbox_in = 32'h0000_0000;
    end

    kw_ready = key_win_s;
    st_ready = (fsm_q == IDLE);
  end

  // Source of retiring results: the S-box directly, or its tagged output register.
  always_comb begin
`ifdef SBOX_PIPE_EN
    ret_vld_s   = pipe_vld_q;
    ret_key_s   = pipe_key_q;
    ret_idx_s   = pipe_idx_q;
    ret_data_s  = pipe_data_q;
    pipe_vld_d  = st_win_s | key_win_s;
    pipe_key_d  = key_win_s;
    pipe_idx_d  = idx_q[1:0];
    pipe_data_d = sbox_out;
`else
    ret_vld_s   = st_win_s | key_win_s;
    ret_key_s   = key_win_s;
    ret_idx_s   = idx_q[1:0];
    ret_data_s  = sbox_out;
`endif
  end

  // Next-state logic for the job FSM, pointer and registered outputs.
  always_comb begin
    fsm_d      = fsm_q;
    idx_d      = idx_q;
    job_d      = job_q;
    res_d      = res_q;
    st_out_d   = st_out_q;
    st_done_d  = 1'b0;
    kw_out_d   = kw_out_q;
    kw_done_d  = 1'b0;
    last_key_d = last_key_q;

    // The pointer only moves when both requesters competed.
    if (contest_s) begin
      last_key_d = key_win_s;
    end else begin
      last_key_d = last_key_q;
    end

    if (st_win_s) begin
      idx_d = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end

    if (ret_vld_s && ret_key_s) begin
      kw_out_d  = ret_data_s;
      kw_done_d = 1'b1;
    end else if (ret_vld_s) begin
      res_d = word_put(res_q, ret_idx_s, ret_data_s);
      // Retiring word3 completes the job and frees the FSM in the same edge,
      // so a new job can be accepted during the st_done cycle.
      if (ret_idx_s == 2'd3) begin
        st_out_d  = word_put(res_q, 2'd3, ret_data_s);
        st_done_d = 1'b1;
        fsm_d     = IDLE;
      end else begin
        st_done_d = 1'b0;
      end
    end else begin
      res_d = res_q;
    end

    // Acceptance is only possible in IDLE, where no state word can retire.
    if ((fsm_q == IDLE) && st_valid) begin
      fsm_d = RUN;
      idx_d = 3'd0;
      job_d = st_in;
    end else begin
      job_d = job_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      idx_q      <= 3'd0;
      job_q      <= 128'd0;
      res_q      <= 128'd0;
      st_out_q   <= 128'd0;
      st_done_q  <= 1'b0;
      kw_out_q   <= 32'd0;
      kw_done_q  <= 1'b0;
      last_key_q <= ~KEY_FIRST;
    end else begin
      fsm_q      <= fsm_d;
      idx_q      <= idx_d;
      job_q      <= job_d;
      res_q      <= res_d;
      st_out_q   <= st_out_d;
      st_done_q  <= st_done_d;
      kw_out_q   <= kw_out_d;
      kw_done_q  <= kw_done_d;
      last_key_q <= last_key_d;
    end
  end

`ifdef SBOX_PIPE_EN
  // Tagged S-box output register; the tag records which requester and word own the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld_q  <= 1'b0;
      pipe_key_q  <= 1'b0;
      pipe_idx_q  <= 2'd0;
      pipe_data_q <= 32'd0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_key_q  <= pipe_key_d;
      pipe_idx_q  <= pipe_idx_d;
      pipe_data_q <= pipe_data_d;
    end
  end
`endif

  assign st_out  = st_out_q;
  assign st_done = st_done_q;
  assign kw_out  = kw_out_q;
  assign kw_done = kw_done_q;

endmodule

// File: tb/tb_sbox_share_sched.sv
// Testbench for sbox_share_sched: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_sbox_share_sched;

`ifdef SBOX_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic clk;

  // DUT A: default KEY_FIRST = 1
  logic         a_rst_n, a_st_valid, a_st_ready, a_st_done, a_kw_valid, a_kw_ready, a_kw_done;
  logic [127:0] a_st_in, a_st_out;
  logic [31:0]  a_kw_in, a_kw_out, a_sbox_in, a_sbox_out;
  // DUT B: KEY_FIRST = 0
  logic         b_rst_n, b_st_valid, b_st_ready, b_st_done, b_kw_valid, b_kw_ready, b_kw_done;
  logic [127:0] b_st_in, b_st_out;
  logic [31:0]  b_kw_in, b_kw_out, b_sbox_in, b_sbox_out;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit           is_key;
    logic [127:0] din;
    logic [127:0] dout;
    int           lat;   // cycles from the accept/grant cycle to the done cycle
  } vec_t;

  vec_t vecs [5];

  // Reference-model state
  bit           m_busy;
  int           m_issued;
  logic [31:0]  m_words [4];
  logic [31:0]  m_res [4];
  bit           m_last_key;
  bit           m_st_pend;
  int           m_st_cyc;
  logic [127:0] m_st_val;
  logic [127:0] m_st_out;
  logic [31:0]  m_kw_out;
  int           kq_cyc [$];
  logic [31:0]  kq_val [$];

  sbox_share_sched u_dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .st_valid(a_st_valid), .st_ready(a_st_ready), .st_in(a_st_in), .st_out(a_st_out), .st_done(a_st_done),
    .kw_valid(a_kw_valid), .kw_ready(a_kw_ready), .kw_in(a_kw_in), .kw_out(a_kw_out), .kw_done(a_kw_done),
    .sbox_in(a_sbox_in), .sbox_out(a_sbox_out)
  );

  sbox_share_sched #(.KEY_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .st_valid(b_st_valid), .st_ready(b_st_ready), .st_in(b_st_in), .st_out(b_st_out), .st_done(b_st_done),
    .kw_valid(b_kw_valid), .kw_ready(b_kw_ready), .kw_in(b_kw_in), .kw_out(b_kw_out), .kw_done(b_kw_done),
    .sbox_in(b_sbox_in), .sbox_out(b_sbox_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AES S-box from first principles: GF(2^8) inverse (a^254) then affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a; inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox8(w[31:24]), sbox8(w[23:16]), sbox8(w[15:8]), sbox8(w[7:0])};
  endfunction

  always_comb a_sbox_out = sub_word(a_sbox_in);
  always_comb b_sbox_out = sub_word(b_sbox_in);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_rst_n = 1'b0; a_st_valid = 1'b0; a_kw_valid = 1'b0; a_st_in = '0; a_kw_in = '0;
    b_rst_n = 1'b0; b_st_valid = 1'b0; b_kw_valid = 1'b0; b_st_in = '0; b_kw_in = '0;
    tick();
    tick();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
  endtask

  // Issue one state job or key word on DUT A and check result, latency and pulse width.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    logic [31:0] seq [4];
    if (v.is_key) begin
      a_kw_valid = 1'b1; a_kw_in = v.din[31:0];
    end else begin
      a_st_valid = 1'b1; a_st_in = v.din;
    end
    #1;
    if (v.is_key) begin
      chk({tag, " kw_ready"}, 128'(a_kw_ready), 128'(1));
      chk({tag, " sbox_in"}, 128'(a_sbox_in), v.din);
    end else begin
      chk({tag, " st_ready"}, 128'(a_st_ready), 128'(1));
    end
    tick();
    // Inputs changing after acceptance must not disturb the job.
    a_st_valid = 1'b0; a_kw_valid = 1'b0; a_st_in = ~v.din; a_kw_in = ~v.din[31:0];
    lat = 1;
    while (!(v.is_key ? a_kw_done : a_st_done) && lat < 24) begin
      #1;
      if (!v.is_key && lat <= 4) seq[lat-1] = a_sbox_in;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 128'(lat), 128'(v.lat));
    chk({tag, " result"}, v.is_key ? 128'(a_kw_out) : a_st_out, v.dout);
    if (!v.is_key) begin
      for (int i = 0; i < 4; i++) chk({tag, " sbox_in seq"}, 128'(seq[i]), 128'(v.din[127-32*i -: 32]));
    end
    tick();
    chk({tag, " done pulse"}, 128'(v.is_key ? a_kw_done : a_st_done), 128'(0));
  endtask

  initial begin
    int k_dones, s_dones, done_k, lat;
    logic [127:0] v0_in, v0_out;
    bit st_c, k_c, k_win, s_win, e_st_done, e_kw_done;
    logic [31:0] e_sbox;

    v0_in  = 128'h00112233_fcfdfeff_00112233_fcfdfeff;
    v0_out = 128'h638293c3_b054bb16_638293c3_b054bb16;
    vecs[0] = '{1'b0, v0_in, v0_out, 5 + PIPE};
    vecs[1] = '{1'b1, 128'h00112233, 128'h638293c3, 1 + PIPE};
    vecs[2] = '{1'b0, 128'h01010101_53535353_00000000_ffffffff,
                128'h7c7c7c7c_edededed_63636363_16161616, 5 + PIPE};
    vecs[3] = '{1'b1, 128'hfcfdfeff, 128'hb054bb16, 1 + PIPE};
    vecs[4] = '{1'b1, 128'h00000000, 128'h63636363, 1 + PIPE};

    // Reset state
    do_reset();
    #1;
    chk("rst st_ready", 128'(a_st_ready), 128'(1));
    chk("rst kw_ready", 128'(a_kw_ready), 128'(0));
    chk("rst st_out", a_st_out, 128'(0));
    chk("rst kw_out", 128'(a_kw_out), 128'(0));
    chk("rst st_done", 128'(a_st_done), 128'(0));
    chk("rst kw_done", 128'(a_kw_done), 128'(0));
    chk("rst sbox_in", 128'(a_sbox_in), 128'(0));
    tick();

    // Directed vector table, uncontested
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Contested: state job plus continuous key traffic; grants alternate, key first
    do_reset();
    a_st_valid = 1'b1; a_st_in = v0_in; a_kw_valid = 1'b1; a_kw_in = 32'hfcfdfeff;
    #1;
    chk("alt accept kw_ready", 128'(a_kw_ready), 128'(1));
    chk("alt accept sbox_in", 128'(a_sbox_in), 128'(32'hfcfdfeff));
    tick();
    a_st_valid = 1'b0;
    k_dones = 0; s_dones = 0; done_k = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 9) a_kw_valid = 1'b0;
      #1;
      if (k <= 8) begin
        chk("alt kw_ready", 128'(a_kw_ready), 128'(k % 2));
        chk("alt sbox_in", 128'(a_sbox_in),
            (k % 2 == 1) ? 128'(32'hfcfdfeff) : 128'(v0_in[127-32*(k/2-1) -: 32]));
      end
      if (a_kw_done) begin
        k_dones++;
        chk("alt kw_out", 128'(a_kw_out), 128'(32'hb054bb16));
      end
      if (a_st_done) begin
        s_dones++;
        if (done_k == 0) done_k = k;
      end
      tick();
    end
    chk("alt st_done cycle", 128'(done_k), 128'(9 + PIPE));
    chk("alt st_done count", 128'(s_dones), 128'(1));
    chk("alt kw_done count", 128'(k_dones), 128'(5));
    chk("alt st_out", a_st_out, v0_out);

    // KEY_FIRST = 0: first contested cycle goes to the state word
    do_reset();
    b_st_valid = 1'b1; b_st_in = v0_in;
    #1;
    chk("kf0 st_ready", 128'(b_st_ready), 128'(1));
    tick();
    b_st_valid = 1'b0; b_kw_valid = 1'b1; b_kw_in = 32'ha5a5a5a5;
    #1;
    chk("kf0 first kw_ready", 128'(b_kw_ready), 128'(0));
    chk("kf0 first sbox_in", 128'(b_sbox_in), 128'(32'h00112233));
    tick();
    #1;
    chk("kf0 second kw_ready", 128'(b_kw_ready), 128'(1));
    chk("kf0 second sbox_in", 128'(b_sbox_in), 128'(32'ha5a5a5a5));
    tick();
    b_kw_valid = 1'b0;
    lat = 3;
    while (!b_st_done && lat < 30) begin
      tick();
      lat++;
    end
    chk("kf0 st latency", 128'(lat), 128'(6 + PIPE));
    chk("kf0 st_out", b_st_out, v0_out);
    chk("kf0 kw_out", 128'(b_kw_out), 128'(sub_word(32'ha5a5a5a5)));

    // Reset during state word2: job discarded, outputs cleared
    a_kw_valid = 1'b1; a_kw_in = 32'h00112233;
    tick();
    a_kw_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid pre kw_out", 128'(a_kw_out), 128'(32'h638293c3));
    a_st_valid = 1'b1; a_st_in = v0_in;
    tick();
    a_st_valid = 1'b0;
    tick();
    tick();
    a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    #1;
    chk("mid st_ready", 128'(a_st_ready), 128'(1));
    chk("mid st_out", a_st_out, 128'(0));
    chk("mid kw_out", 128'(a_kw_out), 128'(0));
    chk("mid st_done", 128'(a_st_done), 128'(0));
    chk("mid kw_done", 128'(a_kw_done), 128'(0));
    chk("mid sbox_in", 128'(a_sbox_in), 128'(0));
    s_dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (a_st_done) s_dones++;
      tick();
    end
    chk("mid no st_done", 128'(s_dones), 128'(0));
    run_vec(vecs[2], "post_rst");

    // Randomized traffic against the reference model
    do_reset();
    m_busy = 1'b0; m_issued = 0; m_last_key = 1'b0; m_st_pend = 1'b0; m_st_cyc = 0;
    m_st_val = '0; m_st_out = '0; m_kw_out = '0;
    kq_cyc.delete(); kq_val.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      a_rst_n    = ($urandom_range(0, 99) != 0);
      a_st_valid = ($urandom_range(0, 2) == 0);
      a_st_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      a_kw_valid = ($urandom_range(0, 1) == 1);
      a_kw_in    = $urandom();
      #1;
      e_st_done = m_st_pend && (m_st_cyc == cyc);
      if (e_st_done) begin
        m_st_out = m_st_val; m_busy = 1'b0; m_st_pend = 1'b0;
      end
      e_kw_done = (kq_cyc.size() > 0) && (kq_cyc[0] == cyc);
      if (e_kw_done) begin
        m_kw_out = kq_val[0];
        void'(kq_cyc.pop_front());
        void'(kq_val.pop_front());
      end
      st_c = m_busy && (m_issued < 4);
      k_c  = a_kw_valid;
      k_win = (st_c && k_c) ? !m_last_key : k_c;
      s_win = st_c && !k_win;
      e_sbox = s_win ? m_words[m_issued] : (k_win ? a_kw_in : 32'h0);
      chk("rnd st_ready", 128'(a_st_ready), 128'(!m_busy));
      chk("rnd kw_ready", 128'(a_kw_ready), 128'(k_win));
      chk("rnd sbox_in", 128'(a_sbox_in), 128'(e_sbox));
      chk("rnd st_done", 128'(a_st_done), 128'(e_st_done));
      chk("rnd st_out", a_st_out, m_st_out);
      chk("rnd kw_done", 128'(a_kw_done), 128'(e_kw_done));
      chk("rnd kw_out", 128'(a_kw_out), 128'(m_kw_out));
      if (!a_rst_n) begin
        m_busy = 1'b0; m_issued = 0; m_last_key = 1'b0; m_st_pend = 1'b0;
        m_st_out = '0; m_kw_out = '0;
        kq_cyc.delete(); kq_val.delete();
      end else begin
        if (st_c && k_c) m_last_key = k_win;
        if (s_win) begin
          m_res[m_issued] = sub_word(m_words[m_issued]);
          m_issued++;
          if (m_issued == 4) begin
            m_st_pend = 1'b1;
            m_st_cyc  = cyc + 1 + PIPE;
            m_st_val  = {m_res[0], m_res[1], m_res[2], m_res[3]};
          end
        end
        if (k_win) begin
          kq_cyc.push_back(cyc + 1 + PIPE);
          kq_val.push_back(sub_word(a_kw_in));
        end
        if (a_st_valid && !m_busy) begin
          m_busy = 1'b1;
          m_issued = 0;
          for (int i = 0; i < 4; i++) m_words[i] = a_st_in[127-32*i -: 32];
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Time-shares one 32-bit combinational s_box (4 byte lanes) between two requesters:
  - the round datapath's SubBytes, 128-bit state processed as 4 words;
  - key expansion's SubWord, a single 32-bit word.
- Sits between aes round control, the key schedule and the single s_box instance.
- Round-robin arbitration on every contested cycle, so neither requester starves.

Parameters:
KEY_FIRST, 1, winner of the first contested cycle after reset (1 = key, 0 = state)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- st_valid  in  1  state job request
- st_ready  out  1  scheduler can accept a state job
- st_in  in  128  state to substitute; word0 = [127:96] … word3 = [31:0]
- st_out  out  128  substituted state; valid when st_done=1
- st_done  out  1  one-cycle pulse, st_out valid
- kw_valid  in  1  key word request
- kw_ready  out  1  key word granted this cycle
- kw_in  in  32  word for SubWord
- kw_out  out  32  substituted key word; valid when kw_done=1
- kw_done  out  1  one-cycle pulse, kw_out valid
- sbox_in  out  32  drives s_box row_in
- sbox_out  in  32  from s_box row_out

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n; sampled only at a rising clk edge.
- Reset values: st_out=0, kw_out=0, st_done=0, kw_done=0, st_ready=1 (combinational from IDLE), kw_ready=0, sbox_in=0, word index=0, last-grant pointer=!KEY_FIRST (state).
- FSM for the state job: IDLE, RUN.
  - st_ready = (FSM==IDLE).
  - A job is accepted at an edge where st_valid & st_ready. At that edge st_in is latched, index=0 and FSM goes to RUN.
- Arbitration, per cycle, purely combinational:
  - Candidates: state = FSM==RUN; key = kw_valid.
  - If only one candidate is present, it wins.
  - If both are present, the winner is the one not granted last. The pointer updates only on contested cycles.
  - kw_ready = key won.
  - sbox_in = current state word if state won, kw_in if key won, else 0.
- State grant: at the edge, result word[index] <= sbox_out and index increments.
  - On the grant of word3: st_out <= full result, st_done <= 1 next cycle, FSM -> IDLE.
  - A new job may therefore be accepted in the st_done cycle.
- Key grant: at the edge, kw_out <= sbox_out and kw_done <= 1 for exactly one cycle. The requester may keep kw_valid high for back-to-back words.
- Latency, uncontested:
  - State: accept edge E0, st_done high in the cycle after E4 (4 s_box cycles).
  - Key: kw_done in the cycle after the grant.
  - Each lost arbitration adds exactly 1 cycle to the state job. A key request waits at most 1 cycle while a state job is running.
- Boundaries:
  - st_valid while RUN is ignored (st_ready=0).
  - Simultaneous state accept and kw_valid: the key may be granted that same cycle, because the state becomes a candidate only in RUN.
  - A key request arriving on the same cycle as word3 follows the pointer rule.
  - Reset mid-job: job discarded, no st_done, all outputs to reset values.
  - st_in and kw_in changing after acceptance/grant has no effect.

Optional Feature:
SBOX_PIPE_EN
- Defined:
  - sbox_out is registered, with a tag register {owner, index}.
  - Results retire one cycle after the grant; st_done and kw_done each arrive one cycle later than stated above.
  - FSM returns to IDLE only when word3 retires, so st_ready is low for one extra cycle.
  - Arbitration is unchanged, and a grant may issue every cycle.
- Undefined: no output register; timing exactly as in Behaviour.

Test Plan:
- Reset, then st_in=00112233_fcfdfeff_00112233_fcfdfeff, no key traffic -> st_done exactly 4 cycles after the accept edge; st_out=638293c3_b054bb16_638293c3_b054bb16; sbox_in sequence 00112233, fcfdfeff, 00112233, fcfdfeff.
- kw_valid=1, kw_in=00112233 while idle -> kw_ready=1 same cycle; next cycle kw_done=1, kw_out=638293c3; kw_done low afterwards.
- State job plus continuous kw_valid (kw_in=fcfdfeff) -> grants alternate key/state; st_done after 8 cycles with correct st_out; kw_out=b054bb16 on every kw_done.
- KEY_FIRST=0, state job and key request contested on the first cycle -> state word0 granted first, key next.
- rst_n low for one cycle during state word2 -> no st_done; st_ready=1 and outputs 0 next cycle; new job 01010101_53535353_00000000_ffffffff -> 7c7c7c7c_edededed_63636363_16161616.
- SBOX_PIPE_EN defined, repeat the first scenario -> st_done 5 cycles after accept, same st_out; key single word -> kw_done 2 cycles after grant.
